// File: rtl/tx_frame_arbiter.sv
// Round-robin, frame-granular arbiter that merges two byte sources into the shared RMII TX FIFO write port.
// Frames are bounded by MAX_LEN and a stall timeout; a frame that is cut off always ends with an EOD byte.
module tx_frame_arbiter #(
  parameter int MAX_LEN = 1518,
  parameter int TIMEOUT = 64
) (
  input  logic        REF_CLK,
  input  logic        arst_n,
  input  logic        s0_req,
  input  logic [7:0]  s0_data,
  input  logic        s0_valid,
  input  logic        s0_last,
  output logic        s0_ready,
  output logic        s0_grant,
  input  logic        s1_req,
  input  logic [7:0]  s1_data,
  input  logic        s1_valid,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic        s1_grant,
  input  logic        fifo_afull,
  output logic        fifo_wren,
  output logic [7:0]  fifo_din,
  output logic        fifo_EOD_in,
  output logic        busy,
  output logic [15:0] frame_count_gray,
  output logic [15:0] abort_count_gray,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BODY  = 3'd1,
    S_ABORT = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [10:0] LEN_LAST  = 11'(MAX_LEN - 1);
  localparam logic [7:0]  IDLE_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_d;
  logic        sel, sel_d;
  logic        last_grant, last_grant_d;
  logic [10:0] byte_cnt, byte_cnt_d;
  logic [7:0]  idle_cnt, idle_cnt_d;
  logic        wren_d;
  logic [7:0]  din_d;
  logic        eod_d;
  logic [15:0] frame_cnt, abort_cnt;
  logic        frame_inc, abort_inc;

  logic        sel_req, sel_valid, sel_last;
  logic [7:0]  sel_data;
  logic        in_frame, accept_phase, hs;

  // Handshake: a byte moves on the rising edge where the granted source has
  // sX_valid=1 and sX_ready=1. Ready is combinational from state and fifo_afull,
  // valid/data/last must be held by the source until that edge.
  assign sel_req   = sel ? s1_req   : s0_req;
  assign sel_valid = sel ? s1_valid : s0_valid;
  assign sel_last  = sel ? s1_last  : s0_last;
  assign sel_data  = sel ? s1_data  : s0_data;

  assign in_frame     = (state == S_BODY) || (state == S_ABORT) || (state == S_DRAIN);
  assign accept_phase = ((state == S_BODY) && !fifo_afull) || (state == S_DRAIN);

  assign s0_grant = in_frame && !sel;
  assign s1_grant = in_frame && sel;
  assign s0_ready = s0_grant && accept_phase;
  assign s1_ready = s1_grant && accept_phase;
  assign hs       = sel_valid && accept_phase;

  assign busy             = (state != S_IDLE);
  assign dbg_state        = state;
  assign frame_count_gray = frame_cnt ^ (frame_cnt >> 1);
  assign abort_count_gray = abort_cnt ^ (abort_cnt >> 1);

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      sel         <= 1'b0;
      last_grant  <= 1'b1;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      fifo_wren   <= 1'b0;
      fifo_din    <= '0;
      fifo_EOD_in <= 1'b0;
      frame_cnt   <= '0;
      abort_cnt   <= '0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      last_grant  <= last_grant_d;
      byte_cnt    <= byte_cnt_d;
      idle_cnt    <= idle_cnt_d;
      fifo_wren   <= wren_d;
      fifo_din    <= din_d;
      fifo_EOD_in <= eod_d;
      frame_cnt   <= frame_cnt + {15'd0, frame_inc};
      abort_cnt   <= abort_cnt + {15'd0, abort_inc};
    end
  end

  always_comb begin
    state_d      = state;
    sel_d        = sel;
    last_grant_d = last_grant;
    byte_cnt_d   = byte_cnt;
    idle_cnt_d   = idle_cnt;
    wren_d       = 1'b0;
    din_d        = fifo_din;
    eod_d        = fifo_EOD_in;
    frame_inc    = 1'b0;
    abort_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (s0_req || s1_req) begin
          // On a tie the source that did not own the previous frame wins.
          sel_d        = (s0_req && s1_req) ? !last_grant : s1_req;
          last_grant_d = sel_d;
          byte_cnt_d   = '0;
          idle_cnt_d   = '0;
          state_d      = S_BODY;
        end
      end
      S_BODY: begin
        if (hs) begin
          wren_d     = 1'b1;
          din_d      = sel_data;
          eod_d      = 1'b0;
          byte_cnt_d = byte_cnt + 11'd1;
          idle_cnt_d = '0;
          if (sel_last) begin
            eod_d     = 1'b1;
            frame_inc = 1'b1;
            state_d   = S_GAP;
          end else if (byte_cnt == LEN_LAST) begin
            eod_d     = 1'b1;
            abort_inc = 1'b1;
            state_d   = S_DRAIN;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          state_d = S_ABORT;
        end else begin
          idle_cnt_d = idle_cnt + 8'd1;
        end
      end
      S_ABORT: begin
        // The closing EOD byte needs a free FIFO entry like any other write.
        if (!fifo_afull) begin
          wren_d    = 1'b1;
          din_d     = 8'h00;
          eod_d     = 1'b1;
          abort_inc = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((hs && sel_last) || !sel_req) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_GAP;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: source drivers, an expected-write scoreboard and per-scenario checks.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;

  localparam int TO = 64;

  logic        REF_CLK = 1'b0;
  logic        arst_n = 1'b0;
  logic        s0_req = 1'b0, s0_valid = 1'b0, s0_last = 1'b0;
  logic [7:0]  s0_data = 8'h00;
  logic        s1_req = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic [7:0]  s1_data = 8'h00;
  logic        s0_ready, s0_grant, s1_ready, s1_grant;
  logic        fifo_afull = 1'b0;
  logic        fifo_wren, fifo_EOD_in, busy;
  logic [7:0]  fifo_din;
  logic [15:0] frame_count_gray, abort_count_gray;
  logic [2:0]  dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  sb_exp;
  bit          sb_en = 1'b0;
  bit          lat_en = 1'b0;
  int          wr_cnt = 0;
  int          ovf_cnt = 0;
  int          cyc_cnt = 0;
  int          last_end_cyc = 0;
  int          gap_q[$];
  int          order_q[$];
  int          live_hs[2];
  int          m_frames = 0;
  int          m_aborts = 0;
  logic        hs_prev = 1'b0, afull_prev = 1'b0, g0_prev = 1'b0, g1_prev = 1'b0;

  tx_frame_arbiter #(.MAX_LEN(1518), .TIMEOUT(TO)) dut (
    .REF_CLK(REF_CLK), .arst_n(arst_n),
    .s0_req(s0_req), .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last),
    .s0_ready(s0_ready), .s0_grant(s0_grant),
    .s1_req(s1_req), .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last),
    .s1_ready(s1_ready), .s1_grant(s1_grant),
    .fifo_afull(fifo_afull), .fifo_wren(fifo_wren), .fifo_din(fifo_din),
    .fifo_EOD_in(fifo_EOD_in), .busy(busy),
    .frame_count_gray(frame_count_gray), .abort_count_gray(abort_count_gray),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 REF_CLK = ~REF_CLK;
  always @(posedge REF_CLK) cyc_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic apply_reset();
    arst_n = 1'b0;
    s0_req = 0; s0_valid = 0; s0_last = 0; s1_req = 0; s1_valid = 0; s1_last = 0;
    fifo_afull = 1'b0;
    repeat (3) @(posedge REF_CLK);
    @(negedge REF_CLK) arst_n = 1'b1;
    @(posedge REF_CLK); #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge REF_CLK);
    @(negedge REF_CLK);
  endtask

  // ---------------- helpers ----------------
  function automatic logic [7:0] bval(input int src, input int idx);
    return 8'(idx * 7 + src * 64 + 1);
  endfunction

  function automatic logic [15:0] gray(input int b);
    logic [15:0] v;
    v = 16'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic push_bytes(input int src, input int n, input bit eod_on_last);
    for (int i = 0; i < n; i++) exp_q.push_back({(eod_on_last && (i == n - 1)), bval(src, i)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_src(input int src, input logic req, input logic vld, input int idx, input logic lst);
    if (src == 0) begin
      s0_req = req; s0_valid = vld; s0_data = bval(0, idx); s0_last = lst;
    end else begin
      s1_req = req; s1_valid = vld; s1_data = bval(1, idx); s1_last = lst;
    end
  endtask

  task automatic drive_frame(input int src, input int nbytes, input bit use_last,
                             input int stall_after, input int stall_len, output int n_hs);
    int   idx, stall, cyc;
    logic hs, stalled;
    idx = 0; stall = 0; cyc = 0;
    live_hs[src] = 0;
    set_src(src, 1'b1, 1'b1, 0, use_last && (nbytes == 1));
    while (idx < nbytes && cyc < 4000) begin
      @(negedge REF_CLK);
      hs = (src == 0) ? (s0_valid & s0_ready) : (s1_valid & s1_ready);
      @(posedge REF_CLK); #1;
      cyc++;
      if (hs) idx++;
      live_hs[src] = idx;
      stalled = (idx == stall_after) && (stall < stall_len);
      if (stalled) stall++;
      set_src(src, 1'b1, !stalled && (idx < nbytes), idx, use_last && (idx == nbytes - 1));
    end
    checks++;
    if (idx < nbytes) begin
      errors++;
      $display("FAIL drive_budget src%0d: accepted %0d bytes, required %0d", src, idx, nbytes);
    end
    set_src(src, 1'b0, 1'b0, 0, 1'b0);
    n_hs = idx;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge REF_CLK) begin
    if (arst_n && sb_en) begin
      if (fifo_wren) begin
        wr_cnt++;
        if (afull_prev) ovf_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_write: got eod=%b din=%h, required no write", fifo_EOD_in, fifo_din);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({fifo_EOD_in, fifo_din} !== sb_exp) begin
            errors++;
            $display("FAIL sb_write: got eod=%b din=%h, required eod=%b din=%h",
                     fifo_EOD_in, fifo_din, sb_exp[8], sb_exp[7:0]);
          end
        end
      end
      if (lat_en) begin
        checks++;
        if (fifo_wren !== hs_prev) begin
          errors++;
          $display("FAIL write_latency: got wren=%b, required %b", fifo_wren, hs_prev);
        end
      end
      if (s0_grant && !g0_prev) begin order_q.push_back(0); gap_q.push_back(cyc_cnt - last_end_cyc); end
      if (s1_grant && !g1_prev) begin order_q.push_back(1); gap_q.push_back(cyc_cnt - last_end_cyc); end
      if ((s0_valid & s0_ready & s0_last) | (s1_valid & s1_ready & s1_last)) last_end_cyc = cyc_cnt;
    end
    hs_prev    = (s0_valid & s0_ready) | (s1_valid & s1_ready);
    afull_prev = fifo_afull;
    g0_prev    = s0_grant;
    g1_prev    = s1_grant;
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({s0_ready, s0_grant, s1_ready, s1_grant, fifo_wren, fifo_din, fifo_EOD_in, busy,
         frame_count_gray, abort_count_gray, dbg_state} !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b%b ready=%b%b wren=%b busy=%b fc=%h ac=%h, required all 0",
               s1_grant, s0_grant, s1_ready, s0_ready, fifo_wren, busy, frame_count_gray, abort_count_gray);
    end
  endtask

  task automatic test_single();
    int n, w0;
    sb_en = 1'b1; lat_en = 1'b1; w0 = wr_cnt;
    push_bytes(0, 64, 1'b1);
    drive_frame(0, 64, 1'b1, -1, 0, n);
    settle();
    lat_en = 1'b0;
    m_frames++;
    checks++; if (n !== 64) begin errors++; $display("FAIL single_hs: got %0d, required 64", n); end
    checks++; if (wr_cnt - w0 !== 64) begin errors++; $display("FAIL single_writes: got %0d, required 64", wr_cnt - w0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_missing: got %0d left, required 0", exp_q.size()); end
    checks++; if (frame_count_gray !== 16'h0001) begin errors++; $display("FAIL single_fc: got %h, required 0001", frame_count_gray); end
    checks++; if (abort_count_gray !== 16'h0000) begin errors++; $display("FAIL single_ac: got %h, required 0000", abort_count_gray); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, required 0", busy); end
  endtask

  task automatic test_alternate();
    int na, nb, nc, nd;
    int exp_order[4];
    apply_reset();
    m_frames = 0; m_aborts = 0;
    order_q.delete(); gap_q.delete();
    exp_order = '{0, 1, 0, 1};
    push_bytes(0, 8, 1'b1); push_bytes(1, 5, 1'b1); push_bytes(0, 6, 1'b1); push_bytes(1, 3, 1'b1);
    fork
      begin drive_frame(0, 8, 1'b1, -1, 0, na); drive_frame(0, 6, 1'b1, -1, 0, nc); end
      begin drive_frame(1, 5, 1'b1, -1, 0, nb); drive_frame(1, 3, 1'b1, -1, 0, nd); end
    join
    settle();
    m_frames += 4;
    checks++; if (order_q.size() !== 4) begin errors++; $display("FAIL alt_grants: got %0d grants, required 4", order_q.size()); end
    for (int i = 0; i < 4 && i < order_q.size(); i++) begin
      checks++;
      if (order_q[i] !== exp_order[i]) begin errors++; $display("FAIL alt_order[%0d]: got s%0d, required s%0d", i, order_q[i], exp_order[i]); end
    end
    for (int i = 1; i < 4 && i < gap_q.size(); i++) begin
      checks++;
      if (gap_q[i] !== 3) begin errors++; $display("FAIL alt_gap[%0d]: got %0d cycles, required 3", i, gap_q[i]); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL alt_missing: got %0d left, required 0", exp_q.size()); end
    checks++; if (frame_count_gray !== gray(m_frames)) begin errors++; $display("FAIL alt_fc: got %h, required %h", frame_count_gray, gray(m_frames)); end
  endtask

  task automatic test_timeout();
    int n0, n1;
    order_q.delete();
    push_bytes(1, 10, 1'b0); exp_q.push_back(9'h100); push_bytes(0, 4, 1'b1);
    fork
      drive_frame(1, 20, 1'b1, 10, TO, n1);
      begin repeat (5) @(posedge REF_CLK); #1; drive_frame(0, 4, 1'b1, -1, 0, n0); end
    join
    settle();
    m_aborts++; m_frames++;
    checks++; if (n1 !== 20) begin errors++; $display("FAIL to_s1_hs: got %0d, required 20", n1); end
    checks++; if (n0 !== 4) begin errors++; $display("FAIL to_s0_hs: got %0d, required 4", n0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL to_missing: got %0d left, required 0", exp_q.size()); end
    checks++; if (abort_count_gray !== gray(m_aborts)) begin errors++; $display("FAIL to_ac: got %h, required %h", abort_count_gray, gray(m_aborts)); end
    checks++; if (frame_count_gray !== gray(m_frames)) begin errors++; $display("FAIL to_fc: got %h, required %h", frame_count_gray, gray(m_frames)); end
    checks++; if (order_q.size() !== 2 || order_q[0] !== 1 || order_q[1] !== 0) begin
      errors++; $display("FAIL to_order: got %0d grants, required s1 then s0", order_q.size());
    end
  endtask

  task automatic test_oversize();
    int n, w0;
    w0 = wr_cnt;
    push_bytes(0, 1518, 1'b1);
    drive_frame(0, 2000, 1'b0, -1, 0, n);
    settle();
    m_aborts++;
    checks++; if (n !== 2000) begin errors++; $display("FAIL big_hs: got %0d, required 2000", n); end
    checks++; if (wr_cnt - w0 !== 1518) begin errors++; $display("FAIL big_writes: got %0d, required 1518", wr_cnt - w0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL big_missing: got %0d left, required 0", exp_q.size()); end
    checks++; if (abort_count_gray !== gray(m_aborts)) begin errors++; $display("FAIL big_ac: got %h, required %h", abort_count_gray, gray(m_aborts)); end
  endtask

  task automatic test_afull(input int hold);
    int n, o0;
    bit aborts;
    o0 = ovf_cnt;
    aborts = (hold >= TO);
    if (aborts) begin push_bytes(0, 12, 1'b0); exp_q.push_back(9'h100); end
    else push_bytes(0, 40, 1'b1);
    fork
      drive_frame(0, 40, 1'b1, -1, 0, n);
      begin
        int w;
        w = 0;
        do begin @(posedge REF_CLK); #2; w++; end while (live_hs[0] < 12 && w < 500);
        fifo_afull = 1'b1;
        repeat (hold) @(posedge REF_CLK);
        #2;
        checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL afull%0d_ready: got %b, required 0", hold, s0_ready); end
        checks++; if (abort_count_gray !== gray(m_aborts)) begin
          errors++; $display("FAIL afull%0d_early_abort: got %h, required %h", hold, abort_count_gray, gray(m_aborts));
        end
        fifo_afull = 1'b0;
      end
    join
    settle();
    if (aborts) m_aborts++; else m_frames++;
    checks++; if (n !== 40) begin errors++; $display("FAIL afull%0d_hs: got %0d, required 40", hold, n); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL afull%0d_missing: got %0d left, required 0", hold, exp_q.size()); end
    checks++; if (ovf_cnt !== o0) begin errors++; $display("FAIL afull%0d_overflow: got %0d writes under afull, required 0", hold, ovf_cnt - o0); end
    checks++; if (abort_count_gray !== gray(m_aborts)) begin errors++; $display("FAIL afull%0d_ac: got %h, required %h", hold, abort_count_gray, gray(m_aborts)); end
    checks++; if (frame_count_gray !== gray(m_frames)) begin errors++; $display("FAIL afull%0d_fc: got %h, required %h", hold, frame_count_gray, gray(m_frames)); end
  endtask

  task automatic test_reset_mid();
    int w;
    sb_en = 1'b0;
    s0_req = 1'b1; s0_valid = 1'b1; s0_data = 8'h55; s0_last = 1'b0;
    w = 0;
    while (!s0_grant && w < 20) begin @(negedge REF_CLK); w++; end
    checks++; if (s0_grant !== 1'b1) begin errors++; $display("FAIL rst_pre_grant: got %b, required 1", s0_grant); end
    repeat (5) @(posedge REF_CLK);
    #3 arst_n = 1'b0;
    #1;
    checks++;
    if ({s0_ready, s0_grant, s1_ready, s1_grant, fifo_wren, fifo_din, fifo_EOD_in, busy,
         frame_count_gray, abort_count_gray, dbg_state} !== 50'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got grant=%b%b ready=%b%b wren=%b busy=%b fc=%h ac=%h, required all 0",
               s1_grant, s0_grant, s1_ready, s0_ready, fifo_wren, busy, frame_count_gray, abort_count_gray);
    end
    @(negedge REF_CLK);
    arst_n = 1'b1;
    s1_req = 1'b1; s1_valid = 1'b1;
    w = 0;
    while (!s0_grant && !s1_grant && w < 20) begin @(negedge REF_CLK); w++; end
    checks++; if ({s1_grant, s0_grant} !== 2'b01) begin
      errors++; $display("FAIL rst_rearb: got s1_grant=%b s0_grant=%b, required s0 only", s1_grant, s0_grant);
    end
    apply_reset();
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_oversize();
    test_afull(20);
    test_afull(TO);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
